// File: rtl/led_scan_scheduler.sv
// HUB75 row-scan sequencer: frame pacing timer, per-row shift/latch/show FSM, buffer swap handshake.
// Optional BRIGHTNESS_EN adds bright[3:0] for PWM-style dimming within the fixed-length SHOW window.
module led_scan_scheduler #(
  parameter int COLS           = 32,
  parameter int ROWS_HALF      = 16,
  parameter int DISPLAY_CYCLES = 256,
  parameter int FRAME_CYCLES   = 250000,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS_HALF),
  localparam int SHOW_W = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1,
  localparam int TMR_W  = $clog2(FRAME_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             swap_req,
`ifdef BRIGHTNESS_EN
  input  logic [3:0]       bright,
`endif
  output logic             swap_ack,
  output logic             front_sel,
  output logic [ROW_W-1:0] rd_row,
  output logic [COL_W-1:0] rd_col,
  output logic             pix_vld,
  output logic [ROW_W-1:0] A,
  output logic             lch,
  output logic             blank,
  output logic             frame_start,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_WAIT, S_SHIFT, S_DRAIN, S_BLANK, S_LATCH, S_SHOW
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [SHOW_W-1:0] show_cnt;
  logic              pending;
  logic              tick;
  logic              scan_last;
  logic              start;

  assign tick      = (timer == TMR_W'(FRAME_CYCLES - 1));
  assign scan_last = (state == S_SHOW) && (show_cnt == SHOW_W'(DISPLAY_CYCLES - 1))
                     && (rd_row == ROW_W'(ROWS_HALF - 1));
  // A pending frame may start straight out of the last SHOW cycle so no WAIT cycle is lost.
  assign start     = (tick | pending) & ((state == S_WAIT) | scan_last);

`ifdef BRIGHTNESS_EN
  logic [3:0]      bright_q;
  logic [SHOW_W:0] on_len;
  assign on_len = (SHOW_W+1)'(((32'(bright_q) + 32'd1) * 32'(DISPLAY_CYCLES)) >> 4);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_WAIT;
      timer       <= '0;
      show_cnt    <= '0;
      pending     <= 1'b1;  // first cycle after release behaves as a tick
      rd_row      <= '0;
      rd_col      <= '0;
      A           <= '0;
      lch         <= 1'b0;
      blank       <= 1'b1;
      pix_vld     <= 1'b0;
      swap_ack    <= 1'b0;
      front_sel   <= 1'b0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
`ifdef BRIGHTNESS_EN
      bright_q    <= '0;
`endif
    end else begin
      timer       <= tick ? '0 : timer + 1'b1;
      pix_vld     <= (state == S_SHIFT);
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      lch         <= 1'b0;

      if (tick && state != S_WAIT)
        overrun <= 1'b1;
      if (start)
        pending <= 1'b0;
      else if (tick)
        pending <= 1'b1;

      if (start) begin
        state       <= S_SHIFT;
        rd_row      <= '0;
        rd_col      <= '0;
        blank       <= 1'b1;
        frame_start <= 1'b1;
        if (swap_req) begin
          front_sel <= ~front_sel;
          swap_ack  <= 1'b1;
        end
`ifdef BRIGHTNESS_EN
        bright_q    <= bright;
`endif
      end else begin
        case (state)
          S_WAIT: blank <= 1'b1;
          S_SHIFT: begin
            if (rd_col == COL_W'(COLS - 1))
              state <= S_DRAIN;
            else
              rd_col <= rd_col + 1'b1;
          end
          S_DRAIN: state <= S_BLANK;
          S_BLANK: begin
            state <= S_LATCH;
            lch   <= 1'b1;
            A     <= rd_row;
          end
          S_LATCH: begin
            state    <= S_SHOW;
            show_cnt <= '0;
`ifdef BRIGHTNESS_EN
            blank    <= (on_len == '0);
`else
            blank    <= 1'b0;
`endif
          end
          S_SHOW: begin
            if (show_cnt == SHOW_W'(DISPLAY_CYCLES - 1)) begin
              blank <= 1'b1;
              if (rd_row == ROW_W'(ROWS_HALF - 1)) begin
                state <= S_WAIT;
              end else begin
                rd_row <= rd_row + 1'b1;
                rd_col <= '0;
                state  <= S_SHIFT;
              end
            end else begin
              show_cnt <= show_cnt + 1'b1;
`ifdef BRIGHTNESS_EN
              blank    <= (({1'b0, show_cnt} + 1'b1) >= on_len);
`else
              blank    <= 1'b0;
`endif
            end
          end
          default: begin
            state <= S_WAIT;
            blank <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
